mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the 32-bit MIPS core, for the variant where one memory and one ALU are shared across cycles of each instruction. It decodes `op`/`funct` from the instruction register and sequences fetch, decode, execute, memory and writeback through a Moore FSM. It drives every datapath select and write-enable, stalls on a memory-ready handshake, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  6  IR[31:26]; stable from the DECODE state until the next FETCH completes.
- `funct`  in  6  IR[5:0]; same stability as `op`.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load enable.
- `pcen`  out  1  PC load enable.
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 00}.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  3  ALU B select: 000 = register B, 001 = 4, 010 = signimm, 011 = signimm<<2, 100 = zeroimm.
- `alucontrol`  out  4  ALU function code: and 0000, or 0001, add 0010, slt 1011, sub 1010, sll 0100, srl 0101, sra 0110, xor 0111.
- `regwrite`  out  1  register-file write enable.
- `wadrsel`  out  2  write-register select: 00 = rt, 01 = rd, 10 = r31.
- `wdsel`  out  2  write-data select: 00 = ALUOut, 01 = memory data register, 10 = PC, 11 = {IR[15:0], 16'b0}.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state encoding, for debug.
- `instret`  out  `CNT_W`  count of retired instructions.

## Operation
State encodings and the outputs each state asserts. Unlisted outputs are 0; `alucontrol` defaults to add.
- 0 FETCH: `alusrcb`=001, `irwrite`=`pcen`=`mem_ready`. Holds while `mem_ready`=0; goes to DECODE when it is 1.
- 1 DECODE: `alusrcb`=011 (branch target into ALUOut). Next state by `op`:
  - lw/sw → MEMADR
  - R-type with a legal funct → RTEXEC
  - beq/bne → BRANCH
  - addi/andi/ori/xori → IEXEC
  - j/jal → JUMP
  - lui → LUI
  - anything else → FETCH with `illegal`=1
- Legal funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, sra 000011.
- 2 MEMADR: `alusrca`=1, `alusrcb`=010. Goes to MEMRD for lw, MEMWR for sw.
- 3 MEMRD: `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- 4 MEMWB: `regwrite`=1, `wadrsel`=00, `wdsel`=01. Goes to FETCH.
- 5 MEMWR: `iord`=1, `memwrite`=1 while waiting. Holds until `mem_ready`, then goes to FETCH.
- 6 RTEXEC: `alusrca`=1, `alusrcb`=000, `alucontrol` from `funct`. Goes to ALUWB.
- 7 ALUWB: `regwrite`=1, `wadrsel`=01, `wdsel`=00. Goes to FETCH.
- 8 BRANCH: `alusrca`=1, `alusrcb`=000, sub, `pcsrc`=01.
  - `pcen` = `zero` for beq, `~zero` for bne.
  - Goes to FETCH.
- 9 IEXEC: `alusrca`=1.
  - addi: `alusrcb`=010, add.
  - andi/ori/xori: `alusrcb`=100 with and/or/xor respectively.
  - Goes to IWB.
- 10 IWB: `regwrite`=1, `wadrsel`=00, `wdsel`=00. Goes to FETCH.
- 11 JUMP: `pcsrc`=10, `pcen`=1. For jal, also `regwrite`=1, `wadrsel`=10, `wdsel`=10; the link value is the old PC+4. Goes to FETCH.
- 12 LUI: `regwrite`=1, `wadrsel`=00, `wdsel`=11. Goes to FETCH.
- Encodings 13–15 are unreachable. If entered, go to FETCH with `illegal`=1.
- `instret` increments by 1, wrapping modulo 2^`CNT_W`, on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IWB, JUMP or LUI. It does not increment on illegal exits.

## Timing
- Outputs decode from `state` only, except:
  - `pcen` in FETCH and BRANCH
  - `irwrite` in FETCH
  - per-op selects in IEXEC and JUMP
- While `reset`=1: `state`=FETCH, `instret`=0, and `illegal`, `regwrite`, `memwrite`, `irwrite`, `pcen` are all 0. Selects show the FETCH values.
- Reset may be asserted mid-instruction: the instruction is abandoned with no further writes and no count.
- After `reset` deasserts, the first rising edge with `mem_ready`=1 in FETCH loads IR and PC.
- Latency with zero wait states:
  - lw: 5 cycles
  - sw, R-type, I-type ALU ops: 4 cycles
  - beq, bne, j, jal, lui: 3 cycles
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. `memwrite` stays high through sw wait states; memory commits only on the `mem_ready` edge.
- `illegal` is high for exactly the DECODE cycle that exits to FETCH (or the unreachable-state cycle).

## Test plan
- Reset released, `mem_ready`=1, `op`=100011: states 0,1,2,3,4,0; `wdsel`=01 and `regwrite`=1 in state 4; `instret` goes 0→1.
- sw with `mem_ready` low for 2 cycles in MEMWR: `memwrite` high 3 consecutive cycles, then FETCH; `instret` +1.
- beq with `zero`=1: `pcen`=1 and `pcsrc`=01 in BRANCH. bne with `zero`=1: `pcen`=0. `alucontrol`=1010 in both.
- jal (`op`=000011): JUMP asserts `pcen`, `pcsrc`=10, `regwrite`, `wadrsel`=10, `wdsel`=10. Plain j (000010): `regwrite`=0.
- R-type `funct`=000011 gives `alucontrol`=0110. `funct`=111111 gives `illegal` pulse, return to FETCH, `instret` unchanged.
- ori in IEXEC gives `alusrcb`=100, `alucontrol`=0001.
- Reset asserted during MEMRD: `state`=0 and all enables 0 immediately (asynchronous); no register write occurs.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory-ready stalls and a retired-instruction counter
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [2:0]       alusrcb,
    output logic [3:0]       alucontrol,
    output logic             regwrite,
    output logic [1:0]       wadrsel,
    output logic [1:0]       wdsel,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_LUI    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    state_t     cur, nxt;
    logic       funct_ok;
    logic [3:0] r_alu;
    logic       retire;

    assign state = cur;

    // R-type funct decode: ALU code plus legality
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = 4'b0010;
        case (funct)
            6'b100000: r_alu = 4'b0010;
            6'b100010: r_alu = 4'b1010;
            6'b100100: r_alu = 4'b0000;
            6'b100101: r_alu = 4'b0001;
            6'b101010: r_alu = 4'b1011;
            6'b000000: r_alu = 4'b0100;
            6'b000010: r_alu = 4'b0101;
            6'b000011: r_alu = 4'b0110;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Next-state and Moore outputs; FETCH strobes are masked while reset is held
    always_comb begin
        nxt        = cur;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 3'b000;
        alucontrol = 4'b0010;
        regwrite   = 1'b0;
        wadrsel    = 2'b00;
        wdsel      = 2'b00;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = 3'b001;
                irwrite = mem_ready & ~reset;
                pcen    = mem_ready & ~reset;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 3'b011;
                case (op)
                    OP_LW, OP_SW:                    nxt = S_MEMADR;
                    OP_R:                            nxt = funct_ok ? S_RTEXEC : S_FETCH;
                    OP_BEQ, OP_BNE:                  nxt = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_IEXEC;
                    OP_J, OP_JAL:                    nxt = S_JUMP;
                    OP_LUI:                          nxt = S_LUI;
                    default:                         nxt = S_FETCH;
                endcase
                illegal = (nxt == S_FETCH);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
                nxt     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                nxt  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                wdsel    = 2'b01;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEXEC: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
                nxt        = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                wadrsel  = 2'b01;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 4'b1010;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BNE) ? ~zero : zero;
                nxt        = S_FETCH;
            end
            S_IEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = (op == OP_ADDI) ? 3'b010 : 3'b100;
                alucontrol = (op == OP_ANDI) ? 4'b0000 :
                             (op == OP_ORI)  ? 4'b0001 :
                             (op == OP_XORI) ? 4'b0111 : 4'b0010;
                nxt        = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                regwrite = (op == OP_JAL);
                wadrsel  = (op == OP_JAL) ? 2'b10 : 2'b00;
                wdsel    = (op == OP_JAL) ? 2'b10 : 2'b00;
                nxt      = S_FETCH;
            end
            S_LUI: begin
                regwrite = 1'b1;
                wdsel    = 2'b11;
                nxt      = S_FETCH;
            end
            default: begin
                illegal = 1'b1;
                nxt     = S_FETCH;
            end
        endcase
    end

    // An instruction retires when a completing state hands back to FETCH
    assign retire = (nxt == S_FETCH) &&
                    (cur inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_LUI});

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for the multicycle MIPS control FSM
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [5:0]  op, funct;
    logic        iord, memwrite, irwrite, pcen, alusrca, regwrite, illegal;
    logic [1:0]  pcsrc, wadrsel, wdsel;
    logic [2:0]  alusrcb;
    logic [3:0]  alucontrol, state;
    logic [31:0] instret;

    string       qn[$];
    logic [23:0] qv[$];
    logic [31:0] qi[$];
    int          compared = 0;
    int          mismatched = 0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .regwrite(regwrite),
        .wadrsel(wadrsel), .wdsel(wdsel), .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Push one cycle's expected outputs, then advance to just after the next rising edge
    task automatic e(input string n, input logic [3:0] st, input logic io, input logic mw,
                     input logic irw, input logic pe, input logic [1:0] ps, input logic asa,
                     input logic [2:0] asb, input logic [3:0] alu, input logic rw,
                     input logic [1:0] wa, input logic [1:0] wd, input logic ill,
                     input logic [31:0] ir);
        qn.push_back(n);
        qv.push_back({st, io, mw, irw, pe, ps, asa, asb, alu, rw, wa, wd, ill});
        qi.push_back(ir);
        @(posedge clk);
        #1;
    endtask

    task automatic fe(input string n, input logic act, input logic [31:0] ir);
        e(n, 4'd0, 0, 0, act, act, 2'b00, 0, 3'b001, 4'b0010, 0, 2'b00, 2'b00, 0, ir);
    endtask

    task automatic de(input string n, input logic ill, input logic [31:0] ir);
        e(n, 4'd1, 0, 0, 0, 0, 2'b00, 0, 3'b011, 4'b0010, 0, 2'b00, 2'b00, ill, ir);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each falling edge
    always @(negedge clk) begin
        if (qv.size() > 0) begin
            string       n;
            logic [23:0] v, act;
            logic [31:0] ir;
            n   = qn.pop_front();
            v   = qv.pop_front();
            ir  = qi.pop_front();
            act = {state, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
                   regwrite, wadrsel, wdsel, illegal};
            compared++;
            if (act !== v || instret !== ir) begin
                mismatched++;
                $display("FAIL %s: got outputs=%h instret=%0d, expected outputs=%h instret=%0d",
                         n, act, instret, v, ir);
            end
        end
    end

    initial begin
        reset = 1; mem_ready = 1; op = 6'b0; funct = 6'b0; zero = 0;
        @(posedge clk); #1;
        fe("reset_hold", 0, 0);
        reset = 0; op = 6'b100011;
        fe("lw_fetch", 1, 0);
        de("lw_decode", 0, 0);
        e("lw_memadr", 4'd2, 0, 0, 0, 0, 2'b00, 1, 3'b010, 4'b0010, 0, 2'b00, 2'b00, 0, 0);
        e("lw_memrd", 4'd3, 1, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 0);
        e("lw_memwb", 4'd4, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 1, 2'b00, 2'b01, 0, 0);
        op = 6'b101011;
        fe("sw_fetch", 1, 1);
        de("sw_decode", 0, 1);
        e("sw_memadr", 4'd2, 0, 0, 0, 0, 2'b00, 1, 3'b010, 4'b0010, 0, 2'b00, 2'b00, 0, 1);
        mem_ready = 0;
        e("sw_wait1", 4'd5, 1, 1, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 1);
        e("sw_wait2", 4'd5, 1, 1, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 1);
        mem_ready = 1;
        e("sw_commit", 4'd5, 1, 1, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 1);
        op = 6'b000100; zero = 1;
        fe("beq_fetch", 1, 2);
        de("beq_decode", 0, 2);
        e("beq_taken", 4'd8, 0, 0, 0, 1, 2'b01, 1, 3'b000, 4'b1010, 0, 2'b00, 2'b00, 0, 2);
        op = 6'b000101;
        fe("bne_fetch", 1, 3);
        de("bne_decode", 0, 3);
        e("bne_not_taken", 4'd8, 0, 0, 0, 0, 2'b01, 1, 3'b000, 4'b1010, 0, 2'b00, 2'b00, 0, 3);
        op = 6'b000011;
        fe("jal_fetch", 1, 4);
        de("jal_decode", 0, 4);
        e("jal_jump", 4'd11, 0, 0, 0, 1, 2'b10, 0, 3'b000, 4'b0010, 1, 2'b10, 2'b10, 0, 4);
        op = 6'b000010;
        fe("j_fetch", 1, 5);
        de("j_decode", 0, 5);
        e("j_jump", 4'd11, 0, 0, 0, 1, 2'b10, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 5);
        op = 6'b000000; funct = 6'b000011;
        fe("sra_fetch", 1, 6);
        de("sra_decode", 0, 6);
        e("sra_exec", 4'd6, 0, 0, 0, 0, 2'b00, 1, 3'b000, 4'b0110, 0, 2'b00, 2'b00, 0, 6);
        e("sra_wb", 4'd7, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 1, 2'b01, 2'b00, 0, 6);
        funct = 6'b111111;
        fe("bad_fetch", 1, 7);
        de("bad_decode", 1, 7);
        op = 6'b001101; funct = 6'b000000;
        fe("ori_fetch", 1, 7);
        de("ori_decode", 0, 7);
        e("ori_exec", 4'd9, 0, 0, 0, 0, 2'b00, 1, 3'b100, 4'b0001, 0, 2'b00, 2'b00, 0, 7);
        e("ori_wb", 4'd10, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 1, 2'b00, 2'b00, 0, 7);
        op = 6'b001111;
        fe("lui_fetch", 1, 8);
        de("lui_decode", 0, 8);
        e("lui_wb", 4'd12, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 1, 2'b00, 2'b11, 0, 8);
        op = 6'b100011; mem_ready = 0;
        fe("fetch_stall", 0, 9);
        mem_ready = 1;
        fe("lw2_fetch", 1, 9);
        de("lw2_decode", 0, 9);
        e("lw2_memadr", 4'd2, 0, 0, 0, 0, 2'b00, 1, 3'b010, 4'b0010, 0, 2'b00, 2'b00, 0, 9);
        mem_ready = 0;
        e("lw2_memrd_wait", 4'd3, 1, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0010, 0, 2'b00, 2'b00, 0, 9);
        mem_ready = 1; reset = 1;
        fe("async_reset", 0, 0);
        fe("reset_held", 0, 0);
        reset = 0;
        fe("post_reset_fetch", 1, 0);
        de("post_reset_decode", 0, 0);
        for (int i = 0; i < 10 && qv.size() > 0; i++) @(posedge clk);
        if (qv.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", qv.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
